// File: rtl/pwm_mix_pkg.sv
// Shared types and helpers for the PWM mix scheduler.
package pwm_mix_pkg;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StAccum,
        StCommit
    } mix_state_e;

    localparam int unsigned ATTN_W = 2;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        int unsigned v;
        w = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            w = w + 1;
        end
        return w;
    endfunction

    function automatic logic [31:0] sat_limit(input logic [31:0] value,
                                              input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pwm_mix_channel_scale.sv
// Mute and attenuate one channel sample; sits on the multiplexed accumulator path.
module pwm_mix_channel_scale
    import pwm_mix_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                mute_i,
    input  logic [ATTN_W-1:0]   attn_i,
    output logic [SAMPLE_W-1:0] term_o
);

    always_comb begin
        term_o = mute_i ? '0 : (sample_i >> attn_i);
    end

endmodule

// File: rtl/pwm_mix_scheduler.sv
// Snapshots channel samples per PWM period and mixes them serially into one compare update.
// Define PWM_MIX_CLIP_COUNT_EN to add the saturating o_clip_count output.
module pwm_mix_scheduler
    import pwm_mix_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned SAMPLE_W  = 8,
    parameter int unsigned COMPARE_W = 9,
    parameter int unsigned TOP       = 255
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_CH*SAMPLE_W-1:0] i_samples,
    input  logic [NUM_CH-1:0]          i_mute,
    input  logic [NUM_CH*ATTN_W-1:0]   i_attn,
    input  logic                       i_cycle_end,
    output logic [7:0]                 o_top,
    output logic                       o_top_valid,
    output logic [COMPARE_W-1:0]       o_compare,
    output logic                       o_compare_valid,
    output logic                       o_busy,
    output logic                       o_clip,
    output logic                       o_overrun
`ifdef PWM_MIX_CLIP_COUNT_EN
    ,
    output logic [15:0]                o_clip_count
`endif
);

    localparam int unsigned IDX_W = clog2(NUM_CH);
    localparam int unsigned ACC_W = SAMPLE_W + IDX_W;
    localparam int unsigned LIMIT = TOP + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    mix_state_e state_q, state_d;

    logic [NUM_CH-1:0][SAMPLE_W-1:0] samples_q, samples_d;
    logic [NUM_CH-1:0]               mute_q, mute_d;
    logic [NUM_CH-1:0][ATTN_W-1:0]   attn_q, attn_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [ACC_W-1:0]                acc_q, acc_d;
    logic [COMPARE_W-1:0]            compare_q, compare_d;
    logic                            compare_valid_q, compare_valid_d;
    logic                            clip_q, clip_d;
    logic                            overrun_q, overrun_d;
    logic [SAMPLE_W-1:0]             term;

    pwm_mix_channel_scale #(
        .SAMPLE_W(SAMPLE_W)
    ) u_scale (
        .sample_i(samples_q[idx_q]),
        .mute_i  (mute_q[idx_q]),
        .attn_i  (attn_q[idx_q]),
        .term_o  (term)
    );

    always_comb begin
        state_d         = state_q;
        samples_d       = samples_q;
        mute_d          = mute_q;
        attn_d          = attn_q;
        idx_d           = idx_q;
        acc_d           = acc_q;
        compare_d       = compare_q;
        compare_valid_d = 1'b0;
        clip_d          = 1'b0;
        // A period boundary while a frame is in flight is dropped and flagged.
        overrun_d       = i_cycle_end && ((state_q == StAccum) || (state_q == StCommit));

        case (state_q)
            StInit: begin
                state_d = StIdle;
            end
            StIdle: begin
                if (i_cycle_end) begin
                    samples_d = i_samples;
                    mute_d    = i_mute;
                    attn_d    = i_attn;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_q + ACC_W'(term);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                compare_d       = COMPARE_W'(sat_limit(32'(acc_q), LIMIT));
                compare_valid_d = 1'b1;
                clip_d          = (32'(acc_q) > LIMIT);
                state_d         = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q         <= StInit;
            samples_q       <= '0;
            mute_q          <= '0;
            attn_q          <= '0;
            idx_q           <= '0;
            acc_q           <= '0;
            compare_q       <= '0;
            compare_valid_q <= 1'b0;
            clip_q          <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            samples_q       <= samples_d;
            mute_q          <= mute_d;
            attn_q          <= attn_d;
            idx_q           <= idx_d;
            acc_q           <= acc_d;
            compare_q       <= compare_d;
            compare_valid_q <= compare_valid_d;
            clip_q          <= clip_d;
            overrun_q       <= overrun_d;
        end
    end

`ifdef PWM_MIX_CLIP_COUNT_EN
    logic [15:0] clip_count_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            clip_count_q <= '0;
        end else if (clip_d && (clip_count_q != 16'hFFFF)) begin
            clip_count_q <= clip_count_q + 16'd1;
        end
    end

    assign o_clip_count = clip_count_q;
`endif

    // INIT is entered by reset, so gating with i_reset keeps the strobe low while reset is held.
    assign o_top_valid     = (state_q == StInit) && !i_reset;
    assign o_top           = 8'(TOP);
    assign o_compare       = compare_q;
    assign o_compare_valid = compare_valid_q;
    assign o_clip          = clip_q;
    assign o_overrun       = overrun_q;
    assign o_busy          = (state_q == StAccum) || (state_q == StCommit);

endmodule

// File: tb/tb_pwm_mix_scheduler.sv
// Self-checking bench for pwm_mix_scheduler: vector table, scoreboard and corner-case sequences.
module tb_pwm_mix_scheduler;

    localparam int NUM_CH    = 4;
    localparam int SAMPLE_W  = 8;
    localparam int COMPARE_W = 9;
    localparam int TOP       = 255;
    localparam int LATENCY   = NUM_CH + 2;

    logic                       clk;
    logic                       rst;
    logic [NUM_CH*SAMPLE_W-1:0] samples;
    logic [NUM_CH-1:0]          mute;
    logic [NUM_CH*2-1:0]        attn;
    logic                       ce;
    logic [7:0]                 top;
    logic                       top_valid;
    logic [COMPARE_W-1:0]       compare;
    logic                       compare_valid;
    logic                       busy;
    logic                       clip;
    logic                       overrun;
`ifdef PWM_MIX_CLIP_COUNT_EN
    logic [15:0]                clip_count;
`endif

    pwm_mix_scheduler #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .COMPARE_W(COMPARE_W),
        .TOP      (TOP)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_samples      (samples),
        .i_mute         (mute),
        .i_attn         (attn),
        .i_cycle_end    (ce),
        .o_top          (top),
        .o_top_valid    (top_valid),
        .o_compare      (compare),
        .o_compare_valid(compare_valid),
        .o_busy         (busy),
        .o_clip         (clip),
`ifdef PWM_MIX_CLIP_COUNT_EN
        .o_clip_count   (clip_count),
`endif
        .o_overrun      (overrun)
    );

    typedef struct {
        logic [31:0] smp;
        logic [3:0]  mt;
        logic [7:0]  at;
        int          exp_cmp;
        bit          exp_clip;
    } vec_t;

    typedef struct {
        int cmp;
        bit clp;
        int due;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    int total;
    int bad;
    int cyc;
    int strobe_cnt;
    int ov_cnt;
    int top_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every compare strobe.
    always @(negedge clk) begin
        exp_t e;
        if (compare_valid === 1'b1) begin
            strobe_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("compare", 32'(compare), 32'(e.cmp));
                check("clip", 32'(clip), 32'(e.clp));
                check("latency", 32'(cyc), 32'(e.due));
            end
        end else if (clip === 1'b1) begin
            check("clip_without_strobe", 32'(clip), 32'd0);
        end
        if (overrun === 1'b1) ov_cnt++;
        if (top_valid === 1'b1) begin
            top_cnt++;
            check("top_value", 32'(top), 32'(TOP));
        end
    end

    task automatic frame(input logic [31:0] s, input logic [3:0] m, input logic [7:0] a,
                         input int ec, input bit eclip);
        exp_t e;
        @(posedge clk);
        #1;
        samples = s;
        mute    = m;
        attn    = a;
        ce      = 1'b1;
        e.cmp   = ec;
        e.clp   = eclip;
        e.due   = cyc + LATENCY;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ce = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   base_str;
        int   base_ov;

        total = 0;
        bad = 0;
        cyc = 0;
        strobe_cnt = 0;
        ov_cnt = 0;
        top_cnt = 0;
        rst = 1'b1;
        ce = 1'b0;
        samples = '0;
        mute = '0;
        attn = '0;

        vecs[0] = '{32'h281E140A, 4'h0, 8'h00, 100, 1'b0};
        vecs[1] = '{32'hC8C8C8C8, 4'h0, 8'h00, 256, 1'b1};
        vecs[2] = '{32'hC8C8C8C8, 4'h0, 8'hAA, 200, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 4'h0, 8'hE4, 256, 1'b1};
        vecs[4] = '{32'h00008080, 4'h0, 8'h00, 256, 1'b0};
        vecs[5] = '{32'h00008180, 4'h0, 8'h00, 256, 1'b1};
        vecs[6] = '{32'h000000FF, 4'h0, 8'h00, 255, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 4'hF, 8'h00, 0, 1'b0};
        vecs[8] = '{32'h07193264, 4'h5, 8'h04, 32, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_top_valid", 32'(top_valid), 32'd0);
        check("rst_top", 32'(top), 32'(TOP));
        check("rst_compare", 32'(compare), 32'd0);
        check("rst_compare_valid", 32'(compare_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // INIT cycle with a cycle_end that must be ignored
        @(posedge clk);
        #1;
        rst = 1'b0;
        ce = 1'b1;
        @(negedge clk);
        check("init_top_valid", 32'(top_valid), 32'd1);
        @(posedge clk);
        #1;
        ce = 1'b0;
        @(negedge clk);
        check("idle_top_valid", 32'(top_valid), 32'd0);
        check("init_ce_no_start", 32'(busy), 32'd0);
        check("init_ce_no_overrun", 32'(overrun), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("idle_compare", 32'(compare), 32'd0);
        check("top_strobe_count", 32'(top_cnt), 32'd1);
        check("no_early_strobe", 32'(strobe_cnt), 32'd0);

        // Table of mixing vectors
        for (int i = 0; i < 9; i++) begin
            frame(vecs[i].smp, vecs[i].mt, vecs[i].at, vecs[i].exp_cmp, vecs[i].exp_clip);
            drain();
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("hold", 32'(compare), 32'(vecs[i].exp_cmp));
        end

        // Snapshot: live inputs change right after the boundary
        frame(32'h281E140A, 4'hA, 8'h00, 40, 1'b0);
        samples = '0;
        mute = '0;
        attn = 8'hFF;
        drain();

        // Overrun during ACCUM
        base_str = strobe_cnt;
        base_ov = ov_cnt;
        @(posedge clk);
        #1;
        samples = 32'h281E140A;
        mute = '0;
        attn = '0;
        ce = 1'b1;
        e.cmp = 100;
        e.clp = 1'b0;
        e.due = cyc + LATENCY;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ce = 1'b0;
        @(posedge clk);
        #1;
        ce = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
        drain();
        repeat (4) @(posedge clk);
        check("overrun_accum_pulses", 32'(ov_cnt - base_ov), 32'd1);
        check("overrun_accum_strobes", 32'(strobe_cnt - base_str), 32'd1);

        // Overrun on the COMMIT cycle; must not re-arm
        base_str = strobe_cnt;
        base_ov = ov_cnt;
        @(posedge clk);
        #1;
        ce = 1'b1;
        e.cmp = 100;
        e.clp = 1'b0;
        e.due = cyc + LATENCY;
        sb.push_back(e);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            ce = (i == 5);
        end
        @(posedge clk);
        #1;
        ce = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("commit_ce_no_rearm", 32'(busy), 32'd0);
        drain();
        repeat (8) @(posedge clk);
        check("overrun_commit_pulses", 32'(ov_cnt - base_ov), 32'd1);
        check("overrun_commit_strobes", 32'(strobe_cnt - base_str), 32'd1);

        // Reset in the middle of ACCUM aborts the frame
        base_str = strobe_cnt;
        @(posedge clk);
        #1;
        samples = 32'hC8C8C8C8;
        ce = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("busy_accum", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_compare", 32'(compare), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_top_valid", 32'(top_valid), 32'd0);
        check("abort_compare_valid", 32'(compare_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reinit_top_valid", 32'(top_valid), 32'd1);
        repeat (12) @(posedge clk);
        check("reinit_top_count", 32'(top_cnt), 32'd2);
        check("abort_no_strobe", 32'(strobe_cnt - base_str), 32'd0);

`ifdef PWM_MIX_CLIP_COUNT_EN
        @(negedge clk);
        check("clip_count_after_rst", 32'(clip_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            frame(32'hC8C8C8C8, 4'h0, 8'h00, 256, 1'b1);
            drain();
        end
        @(negedge clk);
        check("clip_count", 32'(clip_count), 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("clip_count_rst", 32'(clip_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
